melody_beat_sequencer: RTL and testbench

- Generates the 8-bit beat index that drives the melody lookup stage (beat-indexed, four 4-bit note outputs).
- Divides the system clock into beat periods and steps the index from 0 to LAST_BEAT.
- Supports start, stop, pause/resume, tempo select and optional looping, so the lookup stage plays the song at a controlled rate.

---
 rtl/melody_beat_sequencer.sv | 110 +++++++++++
 tb/tb_melody_beat_sequencer.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/melody_beat_sequencer.sv
// Beat-index sequencer for the melody lookup stage: divides clk into beat periods and
// steps beats from 0 to LAST_BEAT with start/stop/pause, tempo select and optional looping.
module melody_beat_sequencer #(
   parameter int BEAT_DIV  = 12500000,
   parameter int LAST_BEAT = 67,
   parameter bit LOOP      = 1'b0
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       stop,
   input  logic       pause,
   input  logic [1:0] tempo,
   output logic [7:0] beats,
   output logic       beat_tick,
   output logic       playing,
   output logic       done
);

   // div_cnt must reach 2*BEAT_DIV-1 (slow tempo); period itself needs one more bit.
   localparam int CNT_W = $clog2(2 * BEAT_DIV);
   localparam int PER_W = CNT_W + 1;

   localparam logic [PER_W-1:0] PER_NORM = PER_W'(BEAT_DIV);
   localparam logic [PER_W-1:0] PER_FAST = PER_W'(BEAT_DIV / 2);
   localparam logic [PER_W-1:0] PER_SLOW = PER_W'(2 * BEAT_DIV);
   localparam logic [7:0]       LAST     = 8'(LAST_BEAT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PLAY  = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] div_cnt;
   logic [PER_W-1:0] period;
   logic [PER_W-1:0] tempo_period;
   logic [PER_W-1:0] period_m1;
   logic             wrap;

   always_comb begin
      tempo_period = PER_NORM;
      case (tempo)
         2'b01:   tempo_period = PER_FAST;
         2'b10:   tempo_period = PER_SLOW;
         default: tempo_period = PER_NORM;
      endcase
   end

   assign period_m1 = period - PER_W'(1);
   assign wrap      = ({1'b0, div_cnt} == period_m1);

   // Priority: stop > start > pause > beat advance. Pause freezes div_cnt so a
   // resumed beat finishes the remainder of its period.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         beats     <= 8'd0;
         beat_tick <= 1'b0;
         playing   <= 1'b0;
         done      <= 1'b0;
         div_cnt   <= '0;
         period    <= PER_NORM;
      end else begin
         beat_tick <= 1'b0;
         done      <= 1'b0;
         if (stop) begin
            state   <= IDLE;
            beats   <= 8'd0;
            div_cnt <= '0;
            playing <= 1'b0;
         end else if (start) begin
            state   <= PLAY;
            beats   <= 8'd0;
            div_cnt <= '0;
            period  <= tempo_period;
            playing <= 1'b1;
         end else if (pause && state == PLAY) begin
            state   <= PAUSE;
            playing <= 1'b0;
         end else if (pause && state == PAUSE) begin
            state   <= PLAY;
            playing <= 1'b1;
         end else if (state == PLAY) begin
            if (wrap) begin
               div_cnt <= '0;
               period  <= tempo_period;
               if (beats < LAST) begin
                  beats     <= 8'(beats + 8'd1);
                  beat_tick <= 1'b1;
               end else if (LOOP) begin
                  beats     <= 8'd0;
                  beat_tick <= 1'b1;
               end else begin
                  // Terminal step: rest outputs downstream, no tick, one done pulse.
                  beats   <= 8'd0;
                  state   <= DONE;
                  playing <= 1'b0;
                  done    <= 1'b1;
               end
            end else begin
               div_cnt <= div_cnt + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_melody_beat_sequencer.sv
// Directed bench for melody_beat_sequencer: a non-looping and a looping instance,
// BEAT_DIV=4, LAST_BEAT=5.
module tb_melody_beat_sequencer;

   logic       clk;
   logic       rst_n;
   logic       start0, stop0, pause0;
   logic [1:0] tempo0;
   logic [7:0] beats0;
   logic       tick0, playing0, done0;
   logic       start1, stop1, pause1;
   logic [1:0] tempo1;
   logic [7:0] beats1;
   logic       tick1, playing1, done1;

   int checks;
   int failures;

   melody_beat_sequencer #(.BEAT_DIV(4), .LAST_BEAT(5), .LOOP(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .start(start0), .stop(stop0), .pause(pause0),
      .tempo(tempo0), .beats(beats0), .beat_tick(tick0), .playing(playing0), .done(done0)
   );

   melody_beat_sequencer #(.BEAT_DIV(4), .LAST_BEAT(5), .LOOP(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .stop(stop1), .pause(pause1),
      .tempo(tempo1), .beats(beats1), .beat_tick(tick1), .playing(playing1), .done(done1)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       start;
      logic       stop;
      logic       pause;
      logic [1:0] tempo;
      logic [7:0] beats;
      logic       tick;
      logic       playing;
      logic       done;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic st, input logic sp, input logic pa, input logic [1:0] tp,
                      input logic [7:0] b, input logic t, input logic pl, input logic d);
      vec_t v;
      v.start = st; v.stop = sp; v.pause = pa; v.tempo = tp;
      v.beats = b; v.tick = t; v.playing = pl; v.done = d;
      vecs.push_back(v);
   endtask

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: inputs already set are sampled at this edge; returns 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_pulses();
      start0 = 1'b0; stop0 = 1'b0; pause0 = 1'b0;
      start1 = 1'b0; stop1 = 1'b0; pause1 = 1'b0;
   endtask

   task automatic check0(input string name, input int b, input int t, input int pl, input int d);
      check({name, " beats"},   int'(beats0),   b);
      check({name, " tick"},    int'(tick0),    t);
      check({name, " playing"}, int'(playing0), pl);
      check({name, " done"},    int'(done0),    d);
   endtask

   int ticks_seen;
   int done_seen;

   initial begin
      checks = 0;
      failures = 0;
      rst_n = 1'b1;
      tempo0 = 2'b00;
      tempo1 = 2'b00;
      clear_pulses();

      // reset state
      #2 rst_n = 1'b0;
      #1;
      check0("reset0", 0, 0, 0, 0);
      check("reset1 beats", int'(beats1), 0);
      check("reset1 playing", int'(playing1), 0);
      repeat (3) step();
      rst_n = 1'b1;
      repeat (5) step();
      check0("idle no autoplay", 0, 0, 0, 0);

      // table: full non-looping song, then pause ignored in DONE
      add(1, 0, 0, 2'b00, 8'd0, 0, 1, 0);
      for (int b = 0; b < 5; b++) begin
         for (int k = 0; k < 3; k++) add(0, 0, 0, 2'b00, 8'(b), 0, 1, 0);
         add(0, 0, 0, 2'b00, 8'(b + 1), 1, 1, 0);
      end
      for (int k = 0; k < 3; k++) add(0, 0, 0, 2'b00, 8'd5, 0, 1, 0);
      add(0, 0, 0, 2'b00, 8'd0, 0, 0, 1);
      add(0, 0, 0, 2'b00, 8'd0, 0, 0, 0);
      add(0, 0, 1, 2'b00, 8'd0, 0, 0, 0);
      for (int k = 0; k < 5; k++) add(0, 0, 0, 2'b00, 8'd0, 0, 0, 0);

      foreach (vecs[i]) begin
         start0 = vecs[i].start;
         stop0  = vecs[i].stop;
         pause0 = vecs[i].pause;
         tempo0 = vecs[i].tempo;
         step();
         clear_pulses();
         check0($sformatf("song row %0d", i), int'(vecs[i].beats), int'(vecs[i].tick),
                int'(vecs[i].playing), int'(vecs[i].done));
      end

      // looping instance: wrap to 0 with a tick, never done
      done_seen = 0;
      start1 = 1'b1;
      step();
      clear_pulses();
      for (int r = 1; r <= 28; r++) begin
         step();
         if (done1) done_seen++;
         if (r == 20) begin
            check("loop r20 beats", int'(beats1), 5);
            check("loop r20 tick", int'(tick1), 1);
         end
         if (r == 24) begin
            check("loop wrap beats", int'(beats1), 0);
            check("loop wrap tick", int'(tick1), 1);
            check("loop wrap playing", int'(playing1), 1);
         end
         if (r == 28) begin
            check("loop r28 beats", int'(beats1), 1);
            check("loop r28 tick", int'(tick1), 1);
            check("loop r28 playing", int'(playing1), 1);
         end
      end
      check("loop done pulses", done_seen, 0);

      // pause at div_cnt=2 during beat 3, hold 20 cycles, resume
      start0 = 1'b1;
      step();
      clear_pulses();
      for (int r = 1; r <= 14; r++) step();
      check("pre-pause beats", int'(beats0), 3);
      pause0 = 1'b1;
      step();
      clear_pulses();
      check("paused playing", int'(playing0), 0);
      ticks_seen = 0;
      for (int r = 0; r < 20; r++) begin
         step();
         if (tick0) ticks_seen++;
      end
      check("paused ticks", ticks_seen, 0);
      check("paused beats", int'(beats0), 3);
      pause0 = 1'b1;
      step();
      clear_pulses();
      check0("resume", 3, 0, 1, 0);
      step();
      check0("resume+1", 3, 0, 1, 0);
      step();
      check0("resume+2", 4, 1, 1, 0);

      // tempo change mid-beat on the looping instance
      tempo1 = 2'b00;
      start1 = 1'b1;
      step();
      clear_pulses();
      for (int r = 1; r <= 36; r++) begin
         if (r == 10) tempo1 = 2'b01;
         if (r == 19) tempo1 = 2'b10;
         step();
         case (r)
            11: check("tempo r11 beats", int'(beats1), 2);
            12: check("tempo r12 beats", int'(beats1), 3);
            13: check("tempo r13 beats", int'(beats1), 3);
            14: check("tempo r14 beats", int'(beats1), 4);
            16: check("tempo r16 beats", int'(beats1), 5);
            18: check("tempo r18 beats", int'(beats1), 0);
            20: check("tempo r20 beats", int'(beats1), 1);
            27: check("tempo r27 beats", int'(beats1), 1);
            28: check("tempo r28 beats", int'(beats1), 2);
            36: check("tempo r36 beats", int'(beats1), 3);
            default: ;
         endcase
      end
      tempo1 = 2'b00;

      // stop and start together while playing: stop wins
      start0 = 1'b1;
      step();
      clear_pulses();
      repeat (6) step();
      start0 = 1'b1;
      stop0 = 1'b1;
      step();
      clear_pulses();
      check0("stop+start", 0, 0, 0, 0);
      repeat (5) step();
      check0("after stop", 0, 0, 0, 0);

      // restart while playing
      start0 = 1'b1;
      step();
      clear_pulses();
      repeat (5) step();
      check("pre-restart beats", int'(beats0), 1);
      start0 = 1'b1;
      step();
      clear_pulses();
      check0("restart", 0, 0, 1, 0);
      repeat (3) step();
      check0("restart+3", 0, 0, 1, 0);
      step();
      check0("restart+4", 1, 1, 1, 0);

      // asynchronous reset mid-song at beat 4
      start0 = 1'b1;
      step();
      clear_pulses();
      repeat (16) step();
      check("pre-reset beats", int'(beats0), 4);
      #2 rst_n = 1'b0;
      #1;
      check0("async reset", 0, 0, 0, 0);
      repeat (3) step();
      rst_n = 1'b1;
      ticks_seen = 0;
      for (int r = 0; r < 12; r++) begin
         step();
         if (tick0 || playing0) ticks_seen++;
      end
      check("post-reset activity", ticks_seen, 0);
      check0("post-reset", 0, 0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
